// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle MIPS datapath and its main control unit.
// The slave modport is the controller side and the master modport is the datapath/bench side.
interface multicycle_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       opcode;
   logic             mem_ready;

   logic             PCWrite;
   logic             IorD;
   logic             MemWrite;
   logic             IRWrite;
   logic             ALUSrcA;
   logic             MemtoReg;
   logic             RegWrite;
   logic             RegDst;
   logic             PCWriteCond;
   logic             MemRead;
   logic             Branch;
   logic             BranchNE;
   logic [1:0]       ALUSrcB;
   logic [1:0]       ALUOp;
   logic [1:0]       PCSource;

   logic [3:0]       state;
   logic             illegal;
   logic [CNT_W-1:0] instr_count;

   modport slave (
      input  opcode, mem_ready,
      output PCWrite, IorD, MemWrite, IRWrite, ALUSrcA, MemtoReg, RegWrite,
             RegDst, PCWriteCond, MemRead, Branch, BranchNE,
             ALUSrcB, ALUOp, PCSource, state, illegal, instr_count
   );

   modport master (
      output opcode, mem_ready,
      input  PCWrite, IorD, MemWrite, IRWrite, ALUSrcA, MemtoReg, RegWrite,
             RegDst, PCWriteCond, MemRead, Branch, BranchNE,
             ALUSrcB, ALUOp, PCSource, state, illegal, instr_count
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath, with memory wait states, addi/bne, illegal trap and a retire counter.
// Controls decode combinationally from the current state; mem_ready stalls FETCH, MEMRD and MEMWR.
module multicycle_ctrl #(
   parameter bit EN_ADDI = 1'b1,
   parameter bit EN_BNE  = 1'b1,
   parameter int CNT_W   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   multicycle_ctrl_if.slave     bus
);
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
      S_TRAP   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   state_t           state_q, state_d;
   logic [5:0]       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             retire;

   logic             pc_write, iord, mem_write, ir_write, alu_src_a;
   logic             mem_to_reg, reg_write, reg_dst, pc_write_cond, mem_read;
   logic             branch_eq, branch_ne, illegal;
   logic [1:0]       alu_src_b, alu_op, pc_source;

   // The opcode is captured in DECODE so MEMADR and BRANCH never depend on a live IR.
   always_comb begin : next_state
      state_d = state_q;
      op_d    = op_q;
      retire  = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (bus.mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            op_d = bus.opcode;
            case (bus.opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_BNE:       state_d = EN_BNE ? S_BRANCH : S_TRAP;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = EN_ADDI ? S_ADDIEX : S_TRAP;
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            if (bus.mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_MEMWR: begin
            if (bus.mem_ready) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_EXEC: begin
            state_d = S_RWB;
         end
         S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_ADDIEX: begin
            state_d = S_ADDIWB;
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
      cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_FETCH;
         op_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

   // Everything is held low during reset so an aborted store cannot issue another write.
   always_comb begin : ctrl_decode
      pc_write      = 1'b0;
      iord          = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      alu_src_a     = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      pc_write_cond = 1'b0;
      mem_read      = 1'b0;
      branch_eq     = 1'b0;
      branch_ne     = 1'b0;
      illegal       = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      if (rst) begin
         case (state_q)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = bus.mem_ready;
               pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
               alu_src_b = 2'b11;
            end
            S_MEMADR, S_ADDIEX: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            S_MEMRD: begin
               mem_read = 1'b1;
               iord     = 1'b1;
            end
            S_MEMWB: begin
               mem_to_reg = 1'b1;
               reg_write  = 1'b1;
            end
            S_MEMWR: begin
               mem_write = 1'b1;
               iord      = 1'b1;
            end
            S_EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
            end
            S_RWB: begin
               reg_dst   = 1'b1;
               reg_write = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = 2'b01;
               pc_write_cond = 1'b1;
               pc_source     = 2'b01;
               branch_eq     = (op_q == OP_BEQ);
               branch_ne     = (op_q == OP_BNE);
            end
            S_JUMP: begin
               pc_write  = 1'b1;
               pc_source = 2'b10;
            end
            S_ADDIWB: begin
               reg_write = 1'b1;
            end
            S_TRAP: begin
               illegal = 1'b1;
            end
            default: begin
               illegal = 1'b0;
            end
         endcase
      end
   end

   assign bus.PCWrite     = pc_write;
   assign bus.IorD        = iord;
   assign bus.MemWrite    = mem_write;
   assign bus.IRWrite     = ir_write;
   assign bus.ALUSrcA     = alu_src_a;
   assign bus.MemtoReg    = mem_to_reg;
   assign bus.RegWrite    = reg_write;
   assign bus.RegDst      = reg_dst;
   assign bus.PCWriteCond = pc_write_cond;
   assign bus.MemRead     = mem_read;
   assign bus.Branch      = branch_eq;
   assign bus.BranchNE    = branch_ne;
   assign bus.ALUSrcB     = alu_src_b;
   assign bus.ALUOp       = alu_op;
   assign bus.PCSource    = pc_source;
   assign bus.state       = state_q;
   assign bus.illegal     = illegal;
   assign bus.instr_count = cnt_q;
endmodule
